booth_radix4_mac_seq: RTL and testbench
=======================================

# booth_radix4_mac_seq

Sequential radix-4 Booth multiplier that sits directly downstream of the Booth digit encoding. Each cycle it recodes one overlapping 3-bit window of the multiplier into a partial-product action, selects the matching multiple of the multiplicand, and accumulates it into a double-width product. It gives the FMAC datapath a small, iterative signed multiply with a start/busy/done handshake.

## Interface

- WIDTH, default 8, operand width in bits; must be even and at least 4.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when not busy.
- multiplicand  input  WIDTH  signed two's-complement operand M.
- multiplier  input  WIDTH  signed two's-complement operand Q.
- busy  output  1  high while digits are being accumulated.
- done  output  1  single-cycle pulse when product becomes valid.
- product  output  2*WIDTH  M*Q in two's complement; held until next accepted start.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE + start=1: latch M sign-extended to 2*WIDTH, latch shift register {Q, 1'b0}, clear accumulator and digit counter, go to RUN.
- RUN: examine the low 3 bits {q(i+1), q(i), q(i-1)}.
- Digit action codes: 000→0 (add zero), 001/010→1 (+M), 011→2 (+2M), 100→4 (−2M), 101/110→3 (−M), 111→0.
- Add the selected multiple, shifted left by 2*digit, into the accumulator.
- Then shift the multiplier register right by 2 and increment the counter.
- Leaving RUN: after digit WIDTH/2−1 is accumulated, go to DONE.
- DONE: done=1 for exactly one cycle; product = accumulator. Next state is IDLE.
- Start during DONE: accepted exactly as in IDLE, and the next state is RUN.
- Arithmetic:
  - 2M = M<<1.
  - Negation is two's complement in 2*WIDTH bits.
  - All sums are modulo 2^(2*WIDTH), with no overflow flag; the full signed range is exact, e.g. (−128)·(−128)=16384.
- Start while busy: ignored; operands are not re-latched.
- Reset at any time, including mid-RUN:
  - next state IDLE.
  - busy=0, done=0, product=0.
  - accumulator and counter cleared.
  - any partial result is discarded.
- Reset values: busy=0, done=0, product=0.

## Timing

- Start is sampled on edge E0.
- busy is high in the cycles following edges E0 … E(WIDTH/2−1).
- done and the valid product appear after edge E(WIDTH/2), i.e. latency is WIDTH/2 cycles (4 for WIDTH=8).
- Throughput is one multiply per WIDTH/2+1 cycles; back-to-back operation is possible by asserting start in the DONE cycle.
- product updates only on entry to DONE and is stable at all other times.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Configuration

- BOOTH_UNSIGNED_EN defined:
  - operands are unsigned.
  - M is zero-extended; Q is zero-extended by 2 bits, so {2'b00, Q, 1'b0} yields WIDTH/2+1 digits.
  - latency becomes WIDTH/2+1 cycles.
- BOOTH_UNSIGNED_EN undefined: signed operation as described above.
- Ports and FSM are identical in both builds.

## Test plan

- Reset then idle: rst=1 for 2 cycles → busy=0, done=0, product=16'h0000; with no start, the outputs stay unchanged.
- Basic signed multiply: M=3, Q=5, start for 1 cycle → done exactly 4 cycles later, product=16'h000F, and busy high for 4 cycles.
- Mixed sign and extremes: M=−1, Q=127 → 16'hFF81; M=−128, Q=−128 → 16'h4000; M=−128, Q=127 → 16'hC080.
- Start while busy: M=7, Q=9 started, then start pulsed with M=2, Q=2 during RUN → product=16'h003F, and only one done pulse.
- Back-to-back and mid-op reset:
  - Start asserted in the DONE cycle with M=−3, Q=4 → second product is 16'hFFF4 after another 4 cycles.
  - rst pulsed on cycle 2 of RUN → product=0, IDLE, and no done pulse.
- With BOOTH_UNSIGNED_EN: M=255, Q=255 → product=16'hFE01 after 5 cycles.

Source files
------------

// File: rtl/booth_radix4_mac_seq.sv
// Iterative radix-4 Booth multiplier: one overlapping 3-bit multiplier window per cycle,
// start/busy/done handshake. Define BOOTH_UNSIGNED_EN for unsigned operands (one extra digit).
module booth_radix4_mac_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = WIDTH + 3;
`ifdef BOOTH_UNSIGNED_EN
  localparam int NDIG = WIDTH / 2 + 1;
`else
  localparam int NDIG = WIDTH / 2;
`endif
  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [SW-1:0]   qsr_q, qsr_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   product_q, product_d;

  logic [PW-1:0]   m2;
  logic [PW-1:0]   mult;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   mcand_ext;
  logic [SW-1:0]   qsr_init;

  // The shift register always carries two guard bits above Q so both builds share one width;
  // the signed build simply never reaches the digit that would read them.
`ifdef BOOTH_UNSIGNED_EN
  assign mcand_ext = {{WIDTH{1'b0}}, multiplicand};
  assign qsr_init  = {2'b00, multiplier, 1'b0};
`else
  assign mcand_ext = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
  assign qsr_init  = {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0};
`endif

  always_comb begin
    m2   = mcand_q << 1;
    mult = '0;
    case (qsr_q[2:0])
      3'b001, 3'b010: mult = mcand_q;
      3'b011:         mult = m2;
      3'b100:         mult = -m2;
      3'b101, 3'b110: mult = -mcand_q;
      default:        mult = '0;
    endcase
    addend  = mult << {cnt_q, 1'b0};
    acc_sum = acc_q + addend;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    qsr_d     = qsr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = mcand_ext;
          qsr_d   = qsr_init;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        qsr_d = qsr_q >> 2;
        cnt_d = cnt_q + 1'b1;
        // The last digit's sum goes straight to the product so done and the result line up.
        if (cnt_q == CW'(NDIG - 1)) begin
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = acc_sum;
          state_d   = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      qsr_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      qsr_q     <= qsr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_mac_seq.sv
// Scoreboard bench for booth_radix4_mac_seq: driver pushes expected products, monitor checks on done.
`timescale 1ns/1ps
module tb_booth_radix4_mac_seq;
  localparam int W   = 8;
  localparam int PW  = 2 * W;
  localparam int PER = 10;
`ifdef BOOTH_UNSIGNED_EN
  localparam int LAT = W / 2 + 1;
`else
  localparam int LAT = W / 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic          busy, done;
  logic [PW-1:0] product;

  booth_radix4_mac_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #(PER/2) clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  logic [PW-1:0] exp_q[$];
  time           t0_q[$];
  logic          last_rst = 1'b1;

  always @(posedge clk) last_rst <= rst;

  function automatic logic [PW-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
    longint a, b;
`ifdef BOOTH_UNSIGNED_EN
    a = longint'(m);
    b = longint'(q);
`else
    a = longint'($signed(m));
    b = longint'($signed(q));
`endif
    return PW'(a * b);
  endfunction

  // Directed vectors use literal products in the signed build.
  function automatic logic [PW-1:0] dexp(input logic [PW-1:0] lit, input logic [W-1:0] m,
                                         input logic [W-1:0] q);
`ifdef BOOTH_UNSIGNED_EN
    return model(m, q);
`else
    return lit;
`endif
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from where the DUT updates.
  initial begin : monitor
    logic [PW-1:0] exp_prod;
    int busy_run;
    logic prev_done;
    exp_prod = '0;
    busy_run = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (last_rst) begin
        exp_q.delete();
        t0_q.delete();
        exp_prod = '0;
        busy_run = 0;
        chk("reset_busy", PW'(busy), '0);
        chk("reset_done", PW'(done), '0);
        chk("reset_product", product, '0);
      end else if (done) begin
        chk("done_single_cycle", PW'(prev_done), '0);
        chk("busy_low_at_done", PW'(busy), '0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_prod = exp_q.pop_front();
          chk("product", product, exp_prod);
          chk("latency", PW'((($time - PER/2) - t0_q.pop_front()) / PER), PW'(LAT));
          chk("busy_cycles", PW'(busy_run), PW'(LAT));
        end
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (product !== exp_prod) chk("product_stable", product, exp_prod);
        else n_vec++;
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input logic [PW-1:0] e);
    multiplicand = m;
    multiplier = q;
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    t0_q.push_back($time);
    #1;
    start = 1'b0;
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * LAT + 10 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin : driver
    logic [W-1:0] m, q;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    issue(8'd3, 8'd5, dexp(16'h000F, 8'd3, 8'd5));
    wait_done();
    issue(8'hFF, 8'h7F, dexp(16'hFF81, 8'hFF, 8'h7F));
    wait_done();
    issue(8'h80, 8'h80, dexp(16'h4000, 8'h80, 8'h80));
    wait_done();
    issue(8'h80, 8'h7F, dexp(16'hC080, 8'h80, 8'h7F));
    wait_done();
    issue(8'hFF, 8'hFF, dexp(16'h0001, 8'hFF, 8'hFF));
    wait_done();
`ifdef BOOTH_UNSIGNED_EN
    issue(8'hFF, 8'hFF, 16'hFE01);
    wait_done();
`endif

    // A second start while busy must be ignored.
    issue(8'd7, 8'd9, 16'h003F);
    @(posedge clk);
    #1;
    multiplicand = 8'd2;
    multiplier = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Back-to-back: start is raised while done is high.
    issue(8'd11, 8'd6, dexp(16'h0042, 8'd11, 8'd6));
    wait_done();
    issue(8'hFD, 8'd4, dexp(16'hFFF4, 8'hFD, 8'd4));
    wait_done();

    // Mid-run reset discards the operation; any later done is flagged by the monitor.
    issue(8'd100, 8'd100, model(8'd100, 8'd100));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_product", product, '0);
    chk("midrst_busy", PW'(busy), '0);
    repeat (3 * LAT) @(posedge clk);
    #1;

    for (int k = 0; k < 40; k++) begin
      m = W'($urandom);
      q = W'($urandom);
      issue(m, q, model(m, q));
      wait_done();
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (2 * LAT) @(posedge clk);
    #1;
    chk("queue_drained", PW'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
